// File: rtl/compare_sequencer.sv
// Two-press operand capture and comparator-flag sampling sequencer.
// The first capture-button press latches operand A, the second latches
// operand B. One settle cycle follows, then the comparator flags are
// sampled and the result is held in SHOW for HOLD_CYCLES cycles.
// Saturating per-outcome tallies count the results.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for the press that captures operand A
// WAIT_B | waiting for the press that captures operand B
// CMP    | one settle cycle for the external comparator
// SAMPLE | flags sampled; result/err/tally update on the exit edge
// SHOW   | result held for HOLD_CYCLES cycles; presses ignored
module compare_sequencer #(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  input  logic       clr,
  input  logic       gt_in,
  input  logic       lt_in,
  input  logic       eq_in,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [2:0] result,
  output logic       err,
  output logic       busy,
  output logic       done,
  output logic [3:0] tally_gt,
  output logic [3:0] tally_lt,
  output logic [3:0] tally_eq,
  output logic [2:0] state
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_B = 3'd1;
  localparam logic [2:0] S_CMP    = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_SHOW   = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic          r_btn_q;
  logic          r_armed;
  logic [HW-1:0] r_hold;
  logic [3:0]    r_op_a;
  logic [3:0]    r_op_b;
  logic [2:0]    r_result;
  logic          r_err;
  logic          r_done;
  logic [3:0]    r_tally_gt;
  logic [3:0]    r_tally_lt;
  logic [3:0]    r_tally_eq;

  logic w_btn_rise;
  logic w_onehot;
  logic w_busy;
  logic w_cap_a;
  logic w_cap_b;
  logic w_sample;
  logic w_show;

  // r_armed stays low until btn has been seen low after reset, so a button
  // held through reset release cannot produce a spurious rising edge.
  assign w_btn_rise = btn & ~r_btn_q & r_armed;
  assign w_onehot   = ($countones({gt_in, lt_in, eq_in}) == 1);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Button edge detection registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_btn_q <= btn;
      r_armed <= r_armed | ~btn;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic; unused encodings recover to IDLE.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = w_btn_rise ? S_WAIT_B : S_IDLE;
      S_WAIT_B: w_state_nxt = w_btn_rise ? S_CMP : S_WAIT_B;
      S_CMP:    w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = S_SHOW;
      S_SHOW:   w_state_nxt = (r_hold == HOLD_LAST) ? S_IDLE : S_SHOW;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_busy   = 1'b0;
    w_cap_a  = 1'b0;
    w_cap_b  = 1'b0;
    w_sample = 1'b0;
    w_show   = 1'b0;
    case (r_state)
      S_IDLE:   w_cap_a = w_btn_rise;
      S_WAIT_B: w_cap_b = w_btn_rise;
      S_CMP:    w_busy = 1'b1;
      S_SAMPLE: begin
        w_busy   = 1'b1;
        w_sample = 1'b1;
      end
      S_SHOW: begin
        w_busy = 1'b1;
        w_show = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  // SHOW hold timer: loaded on SHOW entry, terminal count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_hold <= '0;
    else if (w_sample)                   r_hold <= HOLD_LOAD;
    else if (w_show && (r_hold != '0))   r_hold <= r_hold - HOLD_LAST;
  end

  // Operand capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a <= 4'd0;
      r_op_b <= 4'd0;
    end else begin
      if (w_cap_a) r_op_a <= sw;
      if (w_cap_b) r_op_b <= sw;
    end
  end

  // Result, error flag and completion pulse, updated on leaving SAMPLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 3'b000;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_sample;
      if (w_sample) begin
        r_result <= w_onehot ? {eq_in, gt_in, lt_in} : 3'b000;
        r_err    <= ~w_onehot;
      end
    end
  end

  // Saturating tallies; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tally_gt <= 4'd0;
      r_tally_lt <= 4'd0;
      r_tally_eq <= 4'd0;
    end else if (clr) begin
      r_tally_gt <= 4'd0;
      r_tally_lt <= 4'd0;
      r_tally_eq <= 4'd0;
    end else if (w_sample && w_onehot) begin
      if (gt_in) r_tally_gt <= sat_inc(r_tally_gt);
      if (lt_in) r_tally_lt <= sat_inc(r_tally_lt);
      if (eq_in) r_tally_eq <= sat_inc(r_tally_eq);
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign result   = r_result;
  assign err      = r_err;
  assign busy     = w_busy;
  assign done     = r_done;
  assign tally_gt = r_tally_gt;
  assign tally_lt = r_tally_lt;
  assign tally_eq = r_tally_eq;
  assign state    = r_state;

endmodule

// File: tb/tb_compare_sequencer.sv
// Scoreboard bench for compare_sequencer: each issued sequence pushes its
// predicted outcome; a monitor pops and compares whenever done pulses.
module tb_compare_sequencer;

  localparam int HOLD = 4;

  logic       clk, rst_n, btn, clr, gt_in, lt_in, eq_in;
  logic [3:0] sw;
  logic [3:0] op_a, op_b, tally_gt, tally_lt, tally_eq;
  logic [2:0] result, state;
  logic       err, busy, done;

  compare_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .clr(clr),
    .gt_in(gt_in), .lt_in(lt_in), .eq_in(eq_in),
    .op_a(op_a), .op_b(op_b), .result(result), .err(err),
    .busy(busy), .done(done),
    .tally_gt(tally_gt), .tally_lt(tally_lt), .tally_eq(tally_eq),
    .state(state)
  );

  typedef struct {
    logic [3:0] a, b;
    logic [2:0] res;
    logic       err;
    logic [3:0] tg, tl, te;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_tg = 0, m_tl = 0, m_te = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference outcome: exactly one flag set -> that flag is the result and
  // its tally grows (capped at 15); anything else is an error.
  task automatic predict(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] f, input bit clr_now, output exp_t e);
    e.a = a;
    e.b = b;
    if ($countones(f) == 1) begin
      e.res = f;
      e.err = 1'b0;
      if (f[2]) m_te = (m_te < 15) ? m_te + 1 : 15;
      if (f[1]) m_tg = (m_tg < 15) ? m_tg + 1 : 15;
      if (f[0]) m_tl = (m_tl < 15) ? m_tl + 1 : 15;
    end else begin
      e.res = 3'b000;
      e.err = 1'b1;
    end
    if (clr_now) begin
      m_tg = 0; m_tl = 0; m_te = 0;
    end
    e.tg = 4'(m_tg);
    e.tl = 4'(m_tl);
    e.te = 4'(m_te);
    e.cyc = 0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_op_a", op_a, e.a);
        check("sb_op_b", op_b, e.b);
        check("sb_result", result, e.res);
        check("sb_err", err, e.err);
        check("sb_tally_gt", tally_gt, e.tg);
        check("sb_tally_lt", tally_lt, e.tl);
        check("sb_tally_eq", tally_eq, e.te);
        check("sb_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic reset_check(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_op_a"}, op_a, 0);
    check({tag, "_op_b"}, op_b, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tallies"}, {tally_gt, tally_lt, tally_eq}, 0);
  endtask

  // opt: 0 plain, 1 clr during SAMPLE, 2 button pressed during SHOW.
  task automatic run_seq(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] f, input int opt);
    exp_t e;
    int cnt;
    @(negedge clk);
    check("idle_before_seq", state, 0);
    sw = a; btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    sw = b; {eq_in, gt_in, lt_in} = f; btn = 1'b1;
    predict(a, b, f, opt == 1, e);
    e.cyc = cyc + 3;
    sb.push_back(e);
    @(negedge clk);
    btn = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      if (opt == 1 && cnt == 1) clr = 1'b1;
      if (opt == 1 && cnt == 2) clr = 1'b0;
      if (opt == 2 && cnt == 3) begin btn = 1'b1; sw = ~a; end
      if (opt == 2 && cnt == 4) btn = 1'b0;
      cnt++;
      @(negedge clk);
    end
    clr = 1'b0; btn = 1'b0;
    check("busy_cycles", cnt, 2 + HOLD);
    check("idle_after_show", state, 0);
    check("op_a_held", op_a, a);
    check("result_kept", result, e.res);
    check("err_kept", err, e.err);
  endtask

  initial begin
    logic [3:0] a, b;
    logic [2:0] f;
    rst_n = 1'b1; btn = 1'b0; clr = 1'b0; sw = 4'd0;
    gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_check("init_rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(4'd9, 4'd3, 3'b010, 0);
    run_seq(4'd5, 4'd5, 3'b100, 0);
    for (int k = 0; k < 16; k++) run_seq(4'd2, 4'd7, 3'b001, 0);
    check("tally_lt_saturated", tally_lt, 15);
    run_seq(4'd8, 4'd1, 3'b011, 0);
    run_seq(4'd6, 4'd6, 3'b000, 0);
    run_seq(4'd12, 4'd10, 3'b010, 2);
    run_seq(4'd1, 4'd14, 3'b001, 1);
    check("clr_at_sample_lt", tally_lt, 0);

    for (int k = 0; k < 24; k++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) f = {a == b, a > b, a < b};
      else f = 3'($urandom_range(0, 7));
      run_seq(a, b, f, ($urandom_range(0, 5) == 0) ? 1 : 0);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        m_tg = 0; m_tl = 0; m_te = 0;
        check("idle_clr_tallies", {tally_gt, tally_lt, tally_eq}, 0);
        check("idle_clr_keeps_result", err, ($countones(f) != 1));
      end
    end

    // Reset while waiting for operand B.
    @(negedge clk); sw = 4'd6; btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    check("in_wait_b", state, 1);
    #2 rst_n = 1'b0;
    #1 reset_check("rst_wait_b");
    @(negedge clk); rst_n = 1'b1;
    m_tg = 0; m_tl = 0; m_te = 0;
    repeat (3) @(negedge clk);
    check("wait_b_rst_idle", state, 0);

    // Reset while showing a result.
    begin
      exp_t e;
      @(negedge clk); sw = 4'd11; btn = 1'b1;
      @(negedge clk); btn = 1'b0;
      @(negedge clk); sw = 4'd4; {eq_in, gt_in, lt_in} = 3'b010; btn = 1'b1;
      predict(4'd11, 4'd4, 3'b010, 1'b0, e);
      e.cyc = cyc + 3;
      sb.push_back(e);
      @(negedge clk); btn = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("in_show", state, 4);
      #2 rst_n = 1'b0;
      #1 reset_check("rst_show");
      @(negedge clk); rst_n = 1'b1;
      m_tg = 0; m_tl = 0; m_te = 0;
      repeat (HOLD + 4) @(negedge clk);
      check("show_rst_idle", state, 0);
    end

    // Button held high across reset release must not capture.
    btn = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("held_btn_no_rise", state, 0);
    btn = 1'b0;
    @(negedge clk); btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    check("rise_after_release", state, 1);
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL timeout: got no completion expected finish before limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
